// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
// slave = the unit itself; master = the pipeline plus memory that surround it.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] Mem_Addr;
   logic [63:0] Write_Data;
   logic        MemRead;
   logic        MemWrite;
   logic [63:0] Read_Data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, Read_Data,
      output req_ready, resp_valid, resp_rdata, resp_err, Mem_Addr, Write_Data, MemRead, MemWrite
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, Read_Data,
      input  req_ready, resp_valid, resp_rdata, resp_err, Mem_Addr, Write_Data, MemRead, MemWrite
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for a 64-bit byte-addressed memory: sub-dword stores go through read-modify-write.
// Response 1 cycle (error), 2 (load, sd) or 3 (sub-dword store) after accept; req_ready only in IDLE.
module load_store_unit #(
   parameter int MEM_BYTES = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   load_store_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        req_err;
   logic [3:0]  nbytes;
   logic [64:0] end_addr;

   logic        write_q;
   logic        unsigned_q;
   logic [1:0]  size_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [63:0] wr_dat_q;
   logic [63:0] rdata_q;
   logic        err_q;

   logic [5:0]  shamt;
   logic [63:0] size_mask;
   logic [63:0] shifted;
   logic [63:0] load_val;
   logic [63:0] merged;

   assign accept = bus.req_valid && (state == IDLE);

   // Range check is done one bit wider than the address so a request near 2^64 cannot wrap into range.
   always_comb begin
      nbytes   = 4'd1 << bus.req_size;
      end_addr = {1'b0, bus.req_addr} + 65'(nbytes);
      req_err  = ((bus.req_addr[2:0] & (3'(nbytes) - 3'd1)) != 3'd0) ||
                 (end_addr > 65'(MEM_BYTES));
   end

   always_comb begin
      shamt   = {addr_q[2:0], 3'b000};
      shifted = bus.Read_Data >> shamt;
      case (size_q)
         2'd0:    size_mask = 64'h0000_0000_0000_00FF;
         2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      case (size_q)
         2'd0:    load_val = {{56{shifted[7]  & ~unsigned_q}}, shifted[7:0]};
         2'd1:    load_val = {{48{shifted[15] & ~unsigned_q}}, shifted[15:0]};
         2'd2:    load_val = {{32{shifted[31] & ~unsigned_q}}, shifted[31:0]};
         default: load_val = shifted;
      endcase
      merged = (bus.Read_Data & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)                  state_nxt = RESP;
               else if (!bus.req_write)      state_nxt = RD;
               else if (bus.req_size == 2'd3) state_nxt = WR;
               else                          state_nxt = RD;
            end
         end
         RD:      state_nxt = write_q ? WR : RESP;
         WR:      state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= 2'd0;
         addr_q     <= 64'd0;
         wdata_q    <= 64'd0;
         wr_dat_q   <= 64'd0;
         rdata_q    <= 64'd0;
         err_q      <= 1'b0;
      end else if (accept) begin
         write_q    <= bus.req_write;
         unsigned_q <= bus.req_unsigned;
         size_q     <= bus.req_size;
         addr_q     <= bus.req_addr;
         wdata_q    <= bus.req_wdata;
         wr_dat_q   <= bus.req_wdata;
         rdata_q    <= 64'd0;
         err_q      <= req_err;
      end else if (state == RD) begin
         if (write_q) wr_dat_q <= merged;
         else         rdata_q  <= load_val;
      end
   end

   // Enables decode straight from state so an async reset drops them without waiting for an edge.
   always_comb begin
      bus.req_ready  = (state == IDLE);
      bus.resp_valid = (state == RESP);
      bus.resp_rdata = rdata_q;
      bus.resp_err   = err_q;
      bus.MemRead    = (state == RD);
      bus.MemWrite   = (state == WR);
      bus.Mem_Addr   = ((state == RD) || (state == WR)) ? {addr_q[63:3], 3'b000} : 64'd0;
      bus.Write_Data = (state == WR) ? wr_dat_q : 64'd0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: behavioural 64-byte memory, byte-level reference model, response scoreboard.
module tb_load_store_unit;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      logic [63:0] addr;
      logic [63:0] wdat;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [63:0] mem [8];
   logic [7:0]  mb  [64];
   exp_t        sbq [$];
   int          n_vec;
   int          n_err;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_BYTES(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.Read_Data = mem[bus.Mem_Addr[5:3]];

   always @(posedge clk) begin
      if (bus.MemWrite) mem[bus.Mem_Addr[5:3]] <= bus.Write_Data;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic poke(input int a, input logic [63:0] v);
      mem[a/8] <= v;
      for (int i = 0; i < 8; i++) mb[(a & ~7) + i] = v[8*i +: 8];
   endtask

   // Byte-wise reference: what the pipeline should see, and what the memory should be written with.
   task automatic model(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] d, output exp_t e);
      int          nb;
      int          lane;
      int          base;
      logic [64:0] ea;
      nb   = 1 << sz;
      ea   = {1'b0, a} + 65'(nb);
      e    = '{rdata: 64'd0, err: 1'b0, lat: 0, nrd: 0, nwr: 0, addr: {a[63:3], 3'b000}, wdat: 64'd0};
      e.err = ((a % 64'(nb)) != 64'd0) || (ea > 65'd64);
      if (e.err) begin
         e.lat = 1;
      end else begin
         lane = int'(a[2:0]);
         base = int'(a[5:0]) - lane;
         if (!w) begin
            e.lat = 2;
            e.nrd = 1;
            for (int i = 0; i < 8; i++) begin
               if (i < nb) e.rdata[8*i +: 8] = mb[base + lane + i];
               else        e.rdata[8*i +: 8] = (!u && mb[base + lane + nb - 1][7]) ? 8'hFF : 8'h00;
            end
         end else begin
            e.nwr = 1;
            e.nrd = (sz == 2'd3) ? 0 : 1;
            e.lat = (sz == 2'd3) ? 2 : 3;
            for (int i = 0; i < 8; i++) begin
               if (i >= lane && i < lane + nb) mb[base + i] = d[8*(i - lane) +: 8];
               e.wdat[8*i +: 8] = mb[base + i];
            end
         end
      end
   endtask

   // Called and returns at a negedge; leaves req_valid high when hold is set.
   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] d, input logic hold);
      exp_t        e;
      exp_t        got;
      int          cyc;
      int          nrd;
      int          nwr;
      int          both;
      int          rdy_bad;
      logic [63:0] seen_addr;
      logic [63:0] seen_wd;
      logic [63:0] last_rdata;
      model(w, sz, u, a, d, e);
      sbq.push_back(e);
      chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = u;
      bus.req_addr     = a;
      bus.req_wdata    = d;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      cyc = 1; nrd = 0; nwr = 0; both = 0; rdy_bad = 0;
      seen_addr = 64'd0; seen_wd = 64'd0;
      forever begin
         if (bus.MemRead)  begin nrd++; seen_addr = bus.Mem_Addr; end
         if (bus.MemWrite) begin nwr++; seen_addr = bus.Mem_Addr; seen_wd = bus.Write_Data; end
         if (bus.MemRead && bus.MemWrite) both++;
         if (bus.req_ready) rdy_bad++;
         if (bus.resp_valid || cyc >= 10) break;
         @(negedge clk);
         cyc++;
      end
      got = sbq.pop_front();
      chk("resp_latency", 64'(cyc), 64'(got.lat));
      chk("resp_rdata", bus.resp_rdata, got.rdata);
      chk("resp_err", 64'(bus.resp_err), 64'(got.err));
      chk("memread_cycles", 64'(nrd), 64'(got.nrd));
      chk("memwrite_cycles", 64'(nwr), 64'(got.nwr));
      chk("enable_overlap", 64'(both), 64'd0);
      chk("ready_busy", 64'(rdy_bad), 64'd0);
      if (got.nrd + got.nwr > 0) chk("mem_addr", seen_addr, got.addr);
      if (got.nwr > 0)           chk("write_data", seen_wd, got.wdat);
      last_rdata = bus.resp_rdata;
      @(negedge clk);
      chk("resp_pulse", 64'(bus.resp_valid), 64'd0);
      chk("rdata_held", bus.resp_rdata, last_rdata);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ready"},  64'(bus.req_ready),  64'd1);
      chk({tag, "_valid"},  64'(bus.resp_valid), 64'd0);
      chk({tag, "_err"},    64'(bus.resp_err),   64'd0);
      chk({tag, "_rdata"},  bus.resp_rdata,      64'd0);
      chk({tag, "_memrd"},  64'(bus.MemRead),    64'd0);
      chk({tag, "_memwr"},  64'(bus.MemWrite),   64'd0);
      chk({tag, "_addr"},   bus.Mem_Addr,        64'd0);
      chk({tag, "_wdata"},  bus.Write_Data,      64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_seen;
      int rv_seen;
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 64; i++) mb[i] = 8'h00;
      for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
      reset_n          = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 64'd0;
      bus.req_wdata    = 64'd0;
      #1;
      poke(8,    64'h15);
      poke(16,   64'h8000);
      poke(24,   64'h1122_3344_5566_7788);
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      reset_n = 1'b1;
      @(negedge clk);

      issue(1'b0, 2'd3, 1'b0, 64'h08, 64'd0, 1'b0);
      chk("ld8_value", bus.resp_rdata, 64'h15);
      issue(1'b0, 2'd0, 1'b0, 64'h11, 64'd0, 1'b0);
      chk("lb_sext", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      issue(1'b0, 2'd0, 1'b1, 64'h11, 64'd0, 1'b0);
      chk("lbu_zext", bus.resp_rdata, 64'h0000_0000_0000_0080);
      issue(1'b1, 2'd0, 1'b0, 64'h0A, 64'hAB, 1'b0);
      chk("sb_mem", mem[1], 64'h0000_0000_00AB_0015);
      issue(1'b0, 2'd3, 1'b0, 64'h08, 64'd0, 1'b0);
      chk("ld_after_sb", bus.resp_rdata, 64'h0000_0000_00AB_0015);
      issue(1'b0, 2'd2, 1'b0, 64'h06, 64'd0, 1'b0);
      chk("lw_misalign_err", 64'(bus.resp_err), 64'd1);
      issue(1'b1, 2'd3, 1'b0, 64'h40, 64'h5555, 1'b0);
      chk("sd_range_err", 64'(bus.resp_err), 64'd1);
      issue(1'b1, 2'd3, 1'b0, 64'h38, 64'hDEAD_BEEF_0123_4567, 1'b0);
      chk("sd_top_mem", mem[7], 64'hDEAD_BEEF_0123_4567);
      issue(1'b0, 2'd3, 1'b0, 64'h38, 64'd0, 1'b0);
      issue(1'b1, 2'd2, 1'b0, 64'h24, 64'h89AB_CDEF, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 64'h24, 64'd0, 1'b0);
      chk("lw_sext", bus.resp_rdata, 64'hFFFF_FFFF_89AB_CDEF);
      issue(1'b0, 2'd1, 1'b1, 64'h26, 64'd0, 1'b0);
      issue(1'b0, 2'd1, 1'b0, 64'h13, 64'd0, 1'b0);
      issue(1'b1, 2'd1, 1'b0, 64'h3E, 64'hCAFE, 1'b0);

      issue(1'b1, 2'd3, 1'b0, 64'h20, 64'h1234, 1'b1);
      issue(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b0);
      chk("b2b_ld", bus.resp_rdata, 64'h1234);

      // Reset during the read half of a read-modify-write: nothing may be written.
      bus.req_write = 1'b1; bus.req_size = 2'd1; bus.req_unsigned = 1'b0;
      bus.req_addr = 64'h18; bus.req_wdata = 64'hBEEF; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rmw_rd_phase", 64'(bus.MemRead), 64'd1);
      bus.req_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk_quiet("rst_rd");
      wr_seen = 0; rv_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2) reset_n = 1'b1;
         if (bus.MemWrite)   wr_seen++;
         if (bus.resp_valid) rv_seen++;
      end
      chk("rst_rd_nowrite", 64'(wr_seen), 64'd0);
      chk("rst_rd_noresp",  64'(rv_seen), 64'd0);
      chk("rst_rd_mem", mem[3], 64'h1122_3344_5566_7788);
      chk_quiet("rst_rd_after");

      // Reset asserted while MemWrite is high: the write must be suppressed.
      bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_addr = 64'h19;
      bus.req_wdata = 64'h00; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_wr_phase", 64'(bus.MemWrite), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_wr_memwrite", 64'(bus.MemWrite), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_wr_mem", mem[3], 64'h1122_3344_5566_7788);
      chk_quiet("rst_wr_after");

      issue(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 1'b0);
      chk("final_ld18", bus.resp_rdata, 64'h1122_3344_5566_7788);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side controller for the byte-addressed 64-bit data memory.
- Accepts one load or store request at a time from the pipeline over a valid/ready handshake.
- Drives the memory's Mem_Addr / Write_Data / MemRead / MemWrite / Read_Data interface.
- Supports byte, half, word and doubleword sizes, with sign/zero extension on loads and read-modify-write for sub-doubleword stores. The memory always writes 8 bytes, so partial stores must merge into the existing doubleword.

Parameters:
- MEM_BYTES, 64: size of the attached memory in bytes; must be a multiple of 8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  load result; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned or out-of-range request.
- Mem_Addr  out  64  memory address, always 8-aligned.
- Write_Data  out  64  memory write data.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable; the write commits at the rising edge.
- Read_Data  in  64  memory read data, combinational from Mem_Addr.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; req_ready=1.
  - resp_valid, resp_err, MemRead, MemWrite = 0.
  - resp_rdata, Mem_Addr, Write_Data = 0.
  - MemWrite deasserts immediately on reset, not at the next edge.
- Acceptance: a request is accepted at a rising edge with req_valid & req_ready. The request fields are latched at that edge.
- Address terms:
  - base = {req_addr[63:3], 3'b000}; lane = req_addr[2:0]; nbytes = 1<<req_size.
- Error check at acceptance. Any one of the following is an error:
  - misalignment: req_addr mod nbytes != 0;
  - out of range: req_addr + nbytes > MEM_BYTES, computed 65-bit, so no wrap-around.
- FSM states: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - error -> RESP with resp_err=1;
  - load -> RD;
  - store with size 3 -> WR;
  - store with size <3 -> RD.
- RD state:
  - MemRead=1, Mem_Addr=base.
  - Read_Data is captured at the edge leaving RD.
  - Load: extract nbytes starting at byte lane, extend per req_unsigned, go to RESP.
  - Store: merge, i.e. replace bytes lane..lane+nbytes-1 of the captured doubleword with req_wdata[8*nbytes-1:0], then go to WR.
- WR state:
  - MemWrite=1, Mem_Addr=base.
  - Write_Data = merged doubleword, or req_wdata for size 3.
  - Go to RESP.
- RESP state: resp_valid=1 for exactly one cycle, then go to IDLE.
  - resp_rdata and resp_err are held until the next acceptance.
- Enable exclusivity: MemRead and MemWrite are never both 1. Both are 0 outside RD and WR.
- Latency, counted in cycles after the accept edge until resp_valid is high:
  - error: 1;
  - load: 2;
  - store doubleword: 2;
  - sub-doubleword store: 3.
- Throughput: a new request is accepted on the cycle after RESP at the earliest, since req_ready=1 in IDLE. There are no overlapping transactions.
- Signals ignored outside IDLE: req_valid, and req_* changes.
- Reset mid-operation: the transaction is abandoned with no response. If in RD, no write occurs; if asserted during WR before the edge, the write is suppressed.

Test Plan:
- Doubleword load: bench memory preloaded with dword 0x15 at address 8; ld addr 8 -> MemRead high for exactly one cycle with Mem_Addr=8; resp_valid 2 cycles after accept; resp_rdata=0x15, resp_err=0; MemWrite never asserted.
- Byte load extension: byte 0x80 at address 0x11. lb 0x11 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80; lbu 0x11 -> 0x0000_0000_0000_0080; Mem_Addr=0x10 in both.
- Sub-doubleword store (RMW): dword at 8 = 0x15; sb addr 0x0A, wdata 0xAB -> one MemRead cycle, then one MemWrite cycle with Write_Data=0x0000_0000_00AB_0015; resp_valid 3 cycles after accept; a following ld 8 returns 0x0000_0000_00AB_0015.
- Errors: lw addr 0x06 (misaligned) -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, no MemRead/MemWrite. With MEM_BYTES=64, sd addr 0x40 (out of range) -> same response. With MEM_BYTES=64, sd addr 0x38 -> succeeds.
- Back-to-back: req_valid held high with sd 0x20=0x1234 then ld 0x20 -> req_ready low during both transactions; ld accepted the cycle after the sd RESP; resp_rdata=0x1234.
- Reset mid-RMW: sh addr 0x18 accepted, reset_n pulled low during RD -> MemWrite never asserts; memory at 0x18 unchanged; no resp_valid; after release req_ready=1 and all outputs 0.
